arm_hps_system_sram_stream_writer: RTL and testbench
====================================================

// Module: arm_hps_system_sram_stream_writer
// PURPOSE
//  Upstream feeder for the dual-port on-chip SRAM: packs an 8-bit Avalon-ST byte stream into 32-bit words
//  and writes them through the SRAM's second port (s2) as a capture buffer the HPS reads via s1.
//  HPS programs base/length through a 4-register Avalon-MM CSR slave, starts capture, polls/gets done.
// PARAMETERS
//  ADDR_W   10    SRAM word-address width (depth 2**ADDR_W words)
//  LEN_W    12    byte-length / byte-counter width (max capture 2**LEN_W-1 bytes)
// PORTS
//  clk              in   1      system clock (same clock as SRAM)
//  reset_n          in   1      synchronous, active-low reset
//  csr_address      in   2      CSR word select
//  csr_read         in   1      CSR read strobe; readdata valid next cycle (readLatency 1)
//  csr_write        in   1      CSR write strobe
//  csr_writedata    in   32     CSR write data
//  csr_readdata     out  32     CSR read data
//  snk_data         in   8      stream byte
//  snk_valid        in   1      byte valid
//  snk_endofpacket  in   1      last byte of packet; terminates capture early
//  snk_ready        out  1      byte accepted when valid&ready
//  sram_address     out  ADDR_W to SRAM address2
//  sram_chipselect  out  1      to chipselect2
//  sram_write       out  1      to write2
//  sram_byteenable  out  4      to byteenable2
//  sram_writedata   out  32     to writedata2
//  sram_clken       out  1      to clken2; constant 1
//  irq              out  1      level interrupt = done & irq_en
// BEHAVIOUR
//  CSR map: 0 CTRL  [0]start(W1, self-clear) [1]abort(W1) [2]irq_en(RW)
//           1 BASE  [ADDR_W-1:0] start word address (RW)
//           2 LEN   [LEN_W-1:0] capture length in bytes (RW)
//           3 STAT  [0]busy [1]done(sticky, W1C) [LEN_W+15:16]bytes_captured (RO)
//  Reset: all CSRs 0, state IDLE, snk_ready=0, sram_write=sram_chipselect=0, byteenable=0, irq=0, readdata=0.
//  FSM IDLE -> RUN on start (busy=1, done cleared, byte/word counters=0, addr=BASE).
//      start with LEN=0: stay IDLE, set done, no SRAM writes.
//  RUN: snk_ready=1. Byte k placed in lane k%4 (little-endian, lane0=[7:0]).
//      Flush word when lane3 filled, or byte count reaches LEN, or endofpacket accepted.
//      Flush: cycle after the accepting beat, one-cycle sram_write=chipselect=1, byteenable=filled lanes
//      (e.g. 3 bytes -> 4'b0111), address=BASE+word_idx mod 2**ADDR_W (wraps silently).
//      Flush never stalls input: SRAM has no waitrequest, so back-to-back bytes sustained at 1/cycle.
//  RUN -> FLUSH on last byte/endofpacket: snk_ready=0; final write issued; -> IDLE, done=1, busy=0.
//  abort in RUN: discard partial word (no write), -> IDLE, busy=0, done unchanged.
//  start while busy: ignored. Writes to BASE/LEN while busy: stored, take effect at next start.
//  start and abort same write: abort wins when busy; start wins when idle.
//  Same-cycle done set and W1C clear: set wins.
//  bytes_captured counts accepted bytes, frozen at end, cleared at start.
// CONFIGURATION
//  `define SRAM_WRITER_RING_EN: on reaching LEN without endofpacket, done sets (irq) but FSM stays RUN,
//   counters wrap to 0 and address to BASE (circular capture); only abort or endofpacket ends RUN.
//  Without macro: reaching LEN ends capture as above; endofpacket behaviour identical.
// STRUCTURE
//  Package arm_hps_system_sram_writer_pkg: CSR offsets, CTRL/STAT bit indices, state enum
//   (IDLE, RUN, FLUSH), default ADDR_W/LEN_W.
//  Sub-module arm_hps_system_byte_packer: lane shift/accumulate, lane-fill mask, flush request output.
// TESTING
//  BASE=0x010, LEN=8, 8 bytes 0x01..0x08 back-to-back -> writes @0x010=0x04030201 be=F,
//   @0x011=0x08070605 be=F; done=1, STAT bytes=8, irq if irq_en.
//  LEN=6 -> second write @BASE+1 data[15:0]=0x0605, be=4'b0011; done=1.
//  LEN=100, endofpacket on byte 5 -> writes be=F then be=4'b0001; bytes=5; snk_ready drops after flush.
//  BASE=0x3FF, LEN=8 -> writes @0x3FF then @0x000 (wrap).
//  Abort after 3 bytes -> no SRAM write, busy=0, done=0; start with LEN=0 -> done=1, no writes.
//  snk_valid toggling 50% with random gaps -> same data/addresses as back-to-back case; reset_n low mid-RUN
//   -> all outputs to reset values next cycle. Ring-mode build: LEN=4, 12 bytes -> 3 writes @BASE, done stays set.

Source files
------------

// File: rtl/arm_hps_system_sram_writer_pkg.sv
// Shared constants for the SRAM stream writer: CSR map, bit positions, FSM state codes.
// Optional build macro used by the top: SRAM_WRITER_RING_EN.
package arm_hps_system_sram_writer_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 12;

  localparam logic [1:0] CSR_CTRL = 2'd0;
  localparam logic [1:0] CSR_BASE = 2'd1;
  localparam logic [1:0] CSR_LEN  = 2'd2;
  localparam logic [1:0] CSR_STAT = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_BYTES_LSB = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/arm_hps_system_byte_packer.sv
// Accumulates stream bytes into a little-endian 32-bit word; exposes the word and lane mask
// including the byte being accepted this cycle so the caller can write it out directly.
module arm_hps_system_byte_packer
  import arm_hps_system_sram_writer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        accept,
  input  logic        flush,
  input  logic [7:0]  data_byte,
  output logic [31:0] word_next,
  output logic [3:0]  mask_next,
  output logic        lane_full
);

  logic [1:0]  lane;
  logic [31:0] acc;
  logic [3:0]  mask;

  always_comb begin
    word_next = acc;
    mask_next = mask;
    word_next[{lane, 3'b000} +: 8] = data_byte;
    mask_next[lane] = 1'b1;
  end

  assign lane_full = (lane == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane <= '0;
      acc  <= '0;
      mask <= '0;
    end else if (clear || (accept && flush)) begin
      lane <= '0;
      acc  <= '0;
      mask <= '0;
    end else if (accept) begin
      lane <= lane + 2'd1;
      acc  <= word_next;
      mask <= mask_next;
    end
  end

endmodule

// File: rtl/arm_hps_system_sram_stream_writer.sv
// Packs an 8-bit stream into 32-bit SRAM words, CSR-controlled capture with done/irq.
// Build macro SRAM_WRITER_RING_EN selects circular capture when LEN is reached.
//   state    | meaning
//   ST_IDLE  | waiting for start, snk_ready low
//   ST_RUN   | accepting bytes, writing full words
//   ST_FLUSH | final word write in flight, then done
module arm_hps_system_sram_stream_writer
  import arm_hps_system_sram_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [7:0]        snk_data,
  input  logic              snk_valid,
  input  logic              snk_endofpacket,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [3:0]        sram_byteenable,
  output logic [31:0]       sram_writedata,
  output logic              sram_clken,
  output logic              irq
);

  state_t            state;
  logic              irq_en, done;
  logic [ADDR_W-1:0] base_reg, base_lat, word_idx;
  logic [LEN_W-1:0]  len_reg, len_lat, byte_cnt;
  logic [31:0]       rd_mux, pk_word;
  logic [3:0]        pk_mask;
  logic              pk_full, busy, accept, start_req, abort_req;
  logic              last_len, flush_now, pk_clear;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata[31:LEN_W];

  assign busy      = (state != ST_IDLE);
  assign snk_ready = (state == ST_RUN);
  assign accept    = snk_valid && snk_ready;
  assign start_req = csr_write && (csr_address == CSR_CTRL) && csr_writedata[CTRL_START];
  assign abort_req = csr_write && (csr_address == CSR_CTRL) && csr_writedata[CTRL_ABORT];
  assign last_len  = (({1'b0, byte_cnt} + 1'b1) == {1'b0, len_lat});
  assign flush_now = accept && (pk_full || last_len || snk_endofpacket);
  assign pk_clear  = (state != ST_RUN) || abort_req;
  assign sram_clken = 1'b1;
  assign irq       = done && irq_en;

  arm_hps_system_byte_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (pk_clear),
    .accept    (accept),
    .flush     (flush_now),
    .data_byte (snk_data),
    .word_next (pk_word),
    .mask_next (pk_mask),
    .lane_full (pk_full)
  );

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_CTRL: rd_mux[CTRL_IRQ_EN] = irq_en;
      CSR_BASE: rd_mux[ADDR_W-1:0] = base_reg;
      CSR_LEN:  rd_mux[LEN_W-1:0] = len_reg;
      default: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
        rd_mux[STAT_BYTES_LSB +: LEN_W] = byte_cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      irq_en          <= 1'b0;
      done            <= 1'b0;
      base_reg        <= '0;
      base_lat        <= '0;
      len_reg         <= '0;
      len_lat         <= '0;
      byte_cnt        <= '0;
      word_idx        <= '0;
      csr_readdata    <= '0;
      sram_address    <= '0;
      sram_chipselect <= 1'b0;
      sram_write      <= 1'b0;
      sram_byteenable <= '0;
      sram_writedata  <= '0;
    end else begin
      sram_write      <= 1'b0;
      sram_chipselect <= 1'b0;
      sram_byteenable <= '0;
      if (csr_read) csr_readdata <= rd_mux;
      if (csr_write) begin
        case (csr_address)
          CSR_CTRL: irq_en   <= csr_writedata[CTRL_IRQ_EN];
          CSR_BASE: base_reg <= csr_writedata[ADDR_W-1:0];
          CSR_LEN:  len_reg  <= csr_writedata[LEN_W-1:0];
          default:  if (csr_writedata[STAT_DONE]) done <= 1'b0;
        endcase
      end
      // Done-set paths below come after the W1C so a same-cycle set wins.
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            byte_cnt <= '0;
            if (len_reg == '0) begin
              done <= 1'b1;
            end else begin
              state    <= ST_RUN;
              done     <= 1'b0;
              word_idx <= '0;
              base_lat <= base_reg;
              len_lat  <= len_reg;
            end
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state <= ST_IDLE;
          end else if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (flush_now) begin
              sram_write      <= 1'b1;
              sram_chipselect <= 1'b1;
              sram_byteenable <= pk_mask;
              sram_writedata  <= pk_word;
              sram_address    <= base_lat + word_idx;
              word_idx        <= word_idx + 1'b1;
            end
            if (snk_endofpacket) begin
              state <= ST_FLUSH;
            end else if (last_len) begin
`ifdef SRAM_WRITER_RING_EN
              done     <= 1'b1;
              byte_cnt <= '0;
              word_idx <= '0;
`else
              state <= ST_FLUSH;
`endif
            end
          end
        end
        ST_FLUSH: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_hps_system_sram_stream_writer.sv
// Directed bench for the SRAM stream writer: a byte-level model predicts every SRAM write,
// a negedge monitor checks each write against it, and CSR/status values are checked as literals.
module tb_arm_hps_system_sram_stream_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic [7:0]  snk_data;
  logic        snk_valid, snk_endofpacket, snk_ready;
  logic [9:0]  sram_address;
  logic        sram_chipselect, sram_write, sram_clken, irq;
  logic [3:0]  sram_byteenable;
  logic [31:0] sram_writedata;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  bit  mon_on   = 0;
  logic [9:0]  last_addr;
  logic [31:0] last_data;
  logic [3:0]  last_be;

  always #5 clk = ~clk;

  arm_hps_system_sram_stream_writer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .csr_address     (csr_address),
    .csr_read        (csr_read),
    .csr_write       (csr_write),
    .csr_writedata   (csr_writedata),
    .csr_readdata    (csr_readdata),
    .snk_data        (snk_data),
    .snk_valid       (snk_valid),
    .snk_endofpacket (snk_endofpacket),
    .snk_ready       (snk_ready),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_writedata  (sram_writedata),
    .sram_clken      (sram_clken),
    .irq             (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte k carries value k+1; j is the byte position within the current pass over LEN.
  task automatic model_push(input logic [9:0] base, input int len, input int n,
                            input int eop_at, input bit ring);
    int j = 0;
    int w = 0;
    logic [31:0] d = '0;
    logic [3:0]  be = '0;
    for (int k = 0; k < n; k++) begin
      d[8*(j%4) +: 8] = 8'(k + 1);
      be[j%4] = 1'b1;
      if ((j % 4 == 3) || (j == len - 1) || (k == eop_at)) begin
        exp_q.push_back('{addr: 10'(int'(base) + w), data: d, be: be});
        d = '0;
        be = '0;
        w++;
      end
      j++;
      if (ring && j == len && k != eop_at) begin
        j = 0;
        w = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (sram_write) begin
        n_writes++;
        last_addr = sram_address;
        last_data = sram_writedata;
        last_be   = sram_byteenable;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h be 0x%h, none expected",
                   sram_address, sram_writedata, sram_byteenable);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(sram_address), 32'(e.addr));
          chk("wr_data", sram_writedata, e.data);
          chk("wr_be", 32'(sram_byteenable), 32'(e.be));
        end
      end
      chk("cs_eq_write", 32'(sram_chipselect), 32'(sram_write));
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    csr_address = a; csr_read = 1'b1;
    @(posedge clk); #1;
    d = csr_readdata;
    csr_read = 1'b0;
  endtask

  task automatic drive(input int n, input int eop_at, input bit gap);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 500) begin
      @(posedge clk); #1;
      snk_valid       = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
      snk_data        = 8'(k + 1);
      snk_endofpacket = (k == eop_at);
      @(negedge clk);
      if (snk_valid && snk_ready) k++;
      guard++;
    end
    @(posedge clk); #1;
    snk_valid = 1'b0;
    snk_endofpacket = 1'b0;
    n_checks++;
    if (guard >= 500) begin
      n_fail++;
      $display("FAIL drive_timeout: got %0d of %0d bytes accepted", k, n);
    end
  endtask

  task automatic wait_done();
    logic [31:0] d = '0;
    int t = 0;
    while (!d[1] && t < 50) begin
      csr_rd(2'd3, d);
      t++;
    end
    chk("done_reached", 32'(d[1]), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic capture(input logic [9:0] base, input int len, input int n,
                         input int eop_at, input bit gap, input logic [31:0] ctrl);
    model_push(base, len, n, eop_at, 1'b0);
    csr_wr(2'd1, 32'(base));
    csr_wr(2'd2, 32'(len));
    csr_wr(2'd0, ctrl);
    drive(n, eop_at, gap);
    wait_done();
  endtask

  initial begin
    logic [31:0] rd;
    int wcount;
    reset_n = 1'b0;
    csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    snk_data = '0; snk_valid = 1'b0; snk_endofpacket = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1;
    chk("rst_snk_ready", 32'(snk_ready), 32'd0);
    chk("rst_sram_write", 32'(sram_write), 32'd0);
    chk("rst_byteenable", 32'(sram_byteenable), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    chk("clken", 32'(sram_clken), 32'd1);
    reset_n = 1'b1;
    csr_rd(2'd3, rd);
    chk("rst_stat", rd, 32'd0);

`ifndef SRAM_WRITER_RING_EN
    // 8 bytes back-to-back with irq enabled
    model_push(10'h010, 8, 8, -1, 1'b0);
    chk("model_w0_data", exp_q[0].data, 32'h04030201);
    chk("model_w1_addr", 32'(exp_q[1].addr), 32'h011);
    exp_q.delete();
    capture(10'h010, 8, 8, -1, 1'b0, 32'h5);
    chk("t1_last_addr", 32'(last_addr), 32'h011);
    chk("t1_last_data", last_data, 32'h08070605);
    chk("t1_last_be", 32'(last_be), 32'hF);
    csr_rd(2'd3, rd);
    chk("t1_stat", rd, 32'h0008_0002);
    chk("t1_irq", 32'(irq), 32'd1);
    csr_wr(2'd3, 32'h2);
    #1;
    chk("w1c_irq", 32'(irq), 32'd0);

    // LEN=6 partial last word
    capture(10'h010, 6, 6, -1, 1'b0, 32'h5);
    chk("t2_last_addr", 32'(last_addr), 32'h011);
    chk("t2_last_data", last_data, 32'h0000_0605);
    chk("t2_last_be", 32'(last_be), 32'h3);
    csr_rd(2'd3, rd);
    chk("t2_stat", rd, 32'h0006_0002);

    // endofpacket on byte 5 with a long LEN
    capture(10'h010, 100, 5, 4, 1'b0, 32'h1);
    chk("t3_last_be", 32'(last_be), 32'h1);
    chk("t3_last_data", last_data, 32'h0000_0005);
    chk("t3_ready_low", 32'(snk_ready), 32'd0);
    chk("t3_irq_off", 32'(irq), 32'd0);
    csr_rd(2'd3, rd);
    chk("t3_stat", rd, 32'h0005_0002);

    // address wrap at the top of the SRAM
    capture(10'h3FF, 8, 8, -1, 1'b0, 32'h1);
    chk("t4_wrap_addr", 32'(last_addr), 32'h000);

    // gappy input must give the same writes as back-to-back
    capture(10'h010, 8, 8, -1, 1'b1, 32'h1);
    chk("t5_last_data", last_data, 32'h08070605);

    // abort after 3 bytes: no writes, done stays clear
    wcount = n_writes;
    csr_wr(2'd2, 32'd8);
    csr_wr(2'd0, 32'h1);
    drive(3, -1, 1'b0);
    csr_wr(2'd0, 32'h2);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", 32'(n_writes - wcount), 32'd0);
    csr_rd(2'd3, rd);
    chk("abort_stat", rd, 32'h0003_0000);

    // LEN=0 start
    csr_wr(2'd2, 32'd0);
    csr_wr(2'd0, 32'h1);
    repeat (3) @(posedge clk);
    csr_rd(2'd3, rd);
    chk("len0_stat", rd, 32'h0000_0002);
    chk("len0_no_write", 32'(n_writes - wcount), 32'd0);
`else
    // circular capture: LEN=4, 12 bytes, all three words land on BASE
    model_push(10'h020, 4, 12, -1, 1'b1);
    chk("ring_model_w2", exp_q[2].data, 32'h0C0B0A09);
    csr_wr(2'd1, 32'h020);
    csr_wr(2'd2, 32'd4);
    csr_wr(2'd0, 32'h1);
    drive(12, -1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ring_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("ring_last_addr", 32'(last_addr), 32'h020);
    csr_rd(2'd3, rd);
    chk("ring_busy_done", rd & 32'h3, 32'h3);
    csr_wr(2'd0, 32'h2);
    csr_rd(2'd3, rd);
    chk("ring_abort_done_kept", rd & 32'h3, 32'h2);
`endif

    // reset asserted while a word write is on the SRAM port
    exp_q.push_back('{addr: 10'h040, data: 32'h04030201, be: 4'hF});
    csr_wr(2'd1, 32'h040);
    csr_wr(2'd2, 32'd8);
    csr_wr(2'd0, 32'h5);
    drive(4, -1, 1'b0);
    chk("mid_write_active", 32'(sram_write), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_write", 32'(sram_write), 32'd0);
    chk("mid_rst_ready", 32'(snk_ready), 32'd0);
    chk("mid_rst_be", 32'(sram_byteenable), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    reset_n = 1'b1;
    csr_rd(2'd1, rd);
    chk("mid_rst_base", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

endmodule
